// File: rtl/decode_alu_unit.sv
// decode_alu_unit: the CPU's main decoder, ALU-op decoder and ALU.
// The ID half decodes the opcode combinationally into one-hot flags and a
// 6-bit control word. The EX half holds the op in a register, derives the
// ALU operation from it and computes the result combinationally.
module decode_alu_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       opcode,
  input  logic             haz_pass,
  output logic [5:0]       id_ctrl,
  output logic             li,
  output logic             lw,
  output logic             sw,
  output logic             addi,
  output logic             beq,
  output logic             slti,
  output logic             add,
  output logic             jump,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_zero
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned CTRL_W = 6;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_ADDI = 3'b001;
  localparam logic [OP_W-1:0] OP_LI   = 3'b010;
  localparam logic [OP_W-1:0] OP_LW   = 3'b011;
  localparam logic [OP_W-1:0] OP_SW   = 3'b100;
  localparam logic [OP_W-1:0] OP_SLTI = 3'b101;
  localparam logic [OP_W-1:0] OP_BEQ  = 3'b110;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_SLT   = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  logic [OP_W-1:0]   r_ex_op;
  logic              r_ex_vld;
  logic [CTRL_W-1:0] w_ctrl_map;
  logic [WIDTH-1:0]  w_result;

  // Opcode to one-hot flags and the control word {WB, M, EX}.
  always_comb begin
    li   = 1'b0;
    lw   = 1'b0;
    sw   = 1'b0;
    addi = 1'b0;
    beq  = 1'b0;
    slti = 1'b0;
    add  = 1'b0;
    jump = 1'b0;
    w_ctrl_map = '0;
    case (opcode)
      3'b000: begin add  = 1'b1; w_ctrl_map = 6'b01_00_01; end
      3'b001: begin addi = 1'b1; w_ctrl_map = 6'b01_00_10; end
      3'b010: begin li   = 1'b1; w_ctrl_map = 6'b01_00_11; end
      3'b011: begin lw   = 1'b1; w_ctrl_map = 6'b11_10_10; end
      3'b100: begin sw   = 1'b1; w_ctrl_map = 6'b00_01_10; end
      3'b101: begin slti = 1'b1; w_ctrl_map = 6'b01_00_10; end
      3'b110: begin beq  = 1'b1; w_ctrl_map = 6'b00_00_00; end
      default: begin jump = 1'b1; w_ctrl_map = 6'b00_00_00; end
    endcase
    id_ctrl = haz_pass ? w_ctrl_map : '0;
  end

  // ID/EX op register; a bubble clears the valid bit so a stale op never reaches the ALU.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ex_op  <= '0;
      r_ex_vld <= 1'b0;
    end else if (haz_pass) begin
      r_ex_op  <= opcode;
      r_ex_vld <= 1'b1;
    end else begin
      r_ex_vld <= 1'b0;
    end
  end

  // EX-stage ALU operation; bubbles and jumps fall back to ADD.
  always_comb begin
    alu_ctrl = ALU_ADD;
    if (r_ex_vld) begin
      case (r_ex_op)
        OP_ADD, OP_ADDI, OP_LW, OP_SW: alu_ctrl = ALU_ADD;
        OP_BEQ:  alu_ctrl = ALU_SUB;
        OP_SLTI: alu_ctrl = ALU_SLT;
        OP_LI:   alu_ctrl = ALU_PASSB;
        default: alu_ctrl = ALU_ADD;
      endcase
    end
  end

  // Datapath: modular add/sub, signed set-less-than, pass-through of B.
  always_comb begin
    w_result = '0;
    case (alu_ctrl)
      ALU_ADD: w_result = WIDTH'(alu_a + alu_b);
      ALU_SUB: w_result = WIDTH'(alu_a - alu_b);
      ALU_SLT: w_result = ($signed(alu_a) < $signed(alu_b)) ? WIDTH'(1) : '0;
      default: w_result = alu_b;
    endcase
    alu_out  = w_result;
    alu_zero = (w_result == '0);
  end

endmodule

// File: tb/tb_decode_alu_unit.sv
// Directed bench for decode_alu_unit: decode map, EX op latency, bubbles, ALU modes.
module tb_decode_alu_unit;

  logic       clock;
  logic       reset_n;
  logic [2:0] opcode;
  logic       haz_pass;
  logic [5:0] id_ctrl;
  logic       li, lw, sw, addi, beq, slti, add, jump;
  logic [7:0] alu_a, alu_b;
  logic [1:0] alu_ctrl;
  logic [7:0] alu_out;
  logic       alu_zero;

  int n_checks;
  int n_errors;

  decode_alu_unit #(.WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .haz_pass(haz_pass),
    .id_ctrl(id_ctrl), .li(li), .lw(lw), .sw(sw), .addi(addi), .beq(beq),
    .slti(slti), .add(add), .jump(jump), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_zero(alu_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hand-written tables indexed by opcode.
  logic [5:0] exp_ctrl_tbl [8];
  logic [1:0] exp_alu_tbl  [8];
  initial begin
    exp_ctrl_tbl[0] = 6'b010001; exp_ctrl_tbl[1] = 6'b010010;
    exp_ctrl_tbl[2] = 6'b010011; exp_ctrl_tbl[3] = 6'b111010;
    exp_ctrl_tbl[4] = 6'b000110; exp_ctrl_tbl[5] = 6'b010010;
    exp_ctrl_tbl[6] = 6'b000000; exp_ctrl_tbl[7] = 6'b000000;
    exp_alu_tbl[0] = 2'b00; exp_alu_tbl[1] = 2'b00;
    exp_alu_tbl[2] = 2'b11; exp_alu_tbl[3] = 2'b00;
    exp_alu_tbl[4] = 2'b00; exp_alu_tbl[5] = 2'b10;
    exp_alu_tbl[6] = 2'b01; exp_alu_tbl[7] = 2'b00;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; haz_pass = 1'b1; opcode = 3'b010;
    alu_a = 8'h03; alu_b = 8'h04;
    tick(); tick();
    n_checks++;
    if (alu_ctrl !== 2'b00) begin
      n_errors++; $display("FAIL reset_alu_ctrl: got %b expected 00", alu_ctrl);
    end
    n_checks++;
    if (id_ctrl !== 6'b010011) begin
      n_errors++; $display("FAIL reset_id_ctrl: got %b expected 010011", id_ctrl);
    end
    n_checks++;
    if (alu_out !== 8'h07 || alu_zero !== 1'b0) begin
      n_errors++; $display("FAIL reset_alu_out: got %h/%b expected 07/0", alu_out, alu_zero);
    end
    // Leave reset with a bubble so the EX register stays invalid.
    haz_pass = 1'b0;
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (alu_ctrl !== 2'b00) begin
      n_errors++; $display("FAIL post_reset_bubble: got %b expected 00", alu_ctrl);
    end
  endtask

  task automatic test_decode_sweep();
    logic [7:0] flags;
    logic [7:0] exp_flags;
    haz_pass = 1'b1;
    alu_a = 8'h10; alu_b = 8'h05;
    for (int i = 0; i < 8; i++) begin
      opcode = 3'(i);
      #1;
      flags = {jump, beq, slti, sw, lw, li, addi, add};
      exp_flags = 8'h01 << i;
      n_checks++;
      if (flags !== exp_flags) begin
        n_errors++; $display("FAIL sweep_flags op=%0d: got %b expected %b", i, flags, exp_flags);
      end
      n_checks++;
      if (id_ctrl !== exp_ctrl_tbl[i]) begin
        n_errors++; $display("FAIL sweep_id_ctrl op=%0d: got %b expected %b", i, id_ctrl, exp_ctrl_tbl[i]);
      end
      tick();
      n_checks++;
      if (alu_ctrl !== exp_alu_tbl[i]) begin
        n_errors++; $display("FAIL sweep_alu_ctrl op=%0d: got %b expected %b", i, alu_ctrl, exp_alu_tbl[i]);
      end
    end
  endtask

  task automatic test_bubble();
    alu_a = 8'h11; alu_b = 8'h22;
    haz_pass = 1'b1; opcode = 3'b010;
    tick();
    n_checks++;
    if (alu_ctrl !== 2'b11 || alu_out !== 8'h22) begin
      n_errors++; $display("FAIL bubble_prime: got %b/%h expected 11/22", alu_ctrl, alu_out);
    end
    haz_pass = 1'b0; opcode = 3'b011;
    #1;
    n_checks++;
    if (id_ctrl !== 6'b000000 || lw !== 1'b1) begin
      n_errors++; $display("FAIL bubble_id: got id_ctrl=%b lw=%b expected 000000/1", id_ctrl, lw);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (alu_ctrl !== 2'b00 || alu_out !== 8'h33) begin
        n_errors++; $display("FAIL bubble_cycle%0d: got %b/%h expected 00/33", c, alu_ctrl, alu_out);
      end
    end
  endtask

  task automatic test_add_wrap();
    haz_pass = 1'b1; opcode = 3'b001; alu_a = 8'hFF; alu_b = 8'h01;
    tick();
    n_checks++;
    if (alu_ctrl !== 2'b00 || alu_out !== 8'h00 || alu_zero !== 1'b1) begin
      n_errors++; $display("FAIL add_wrap: got %b/%h/%b expected 00/00/1", alu_ctrl, alu_out, alu_zero);
    end
  endtask

  task automatic test_slt();
    haz_pass = 1'b1; opcode = 3'b101; alu_a = 8'hFE; alu_b = 8'h03;
    tick();
    n_checks++;
    if (alu_ctrl !== 2'b10 || alu_out !== 8'h01 || alu_zero !== 1'b0) begin
      n_errors++; $display("FAIL slt_neg_lt: got %b/%h/%b expected 10/01/0", alu_ctrl, alu_out, alu_zero);
    end
    alu_a = 8'h05; alu_b = 8'h80;
    #1;
    n_checks++;
    if (alu_out !== 8'h00 || alu_zero !== 1'b1) begin
      n_errors++; $display("FAIL slt_pos_vs_neg: got %h/%b expected 00/1", alu_out, alu_zero);
    end
  endtask

  task automatic test_sub_passb();
    haz_pass = 1'b1; opcode = 3'b110; alu_a = 8'h2A; alu_b = 8'h2A;
    tick();
    n_checks++;
    if (alu_ctrl !== 2'b01 || alu_out !== 8'h00 || alu_zero !== 1'b1) begin
      n_errors++; $display("FAIL beq_equal: got %b/%h/%b expected 01/00/1", alu_ctrl, alu_out, alu_zero);
    end
    alu_a = 8'h03; alu_b = 8'h05;
    #1;
    n_checks++;
    if (alu_out !== 8'hFE || alu_zero !== 1'b0) begin
      n_errors++; $display("FAIL beq_sub_wrap: got %h/%b expected FE/0", alu_out, alu_zero);
    end
    opcode = 3'b010; alu_a = 8'h77; alu_b = 8'h0C;
    tick();
    n_checks++;
    if (alu_ctrl !== 2'b11 || alu_out !== 8'h0C) begin
      n_errors++; $display("FAIL li_passb: got %b/%h expected 11/0C", alu_ctrl, alu_out);
    end
    alu_b = 8'h00;
    #1;
    n_checks++;
    if (alu_zero !== 1'b1) begin
      n_errors++; $display("FAIL li_zero: got %b expected 1", alu_zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [6];
    seq[0] = 3'b101; seq[1] = 3'b110; seq[2] = 3'b010;
    seq[3] = 3'b111; seq[4] = 3'b011; seq[5] = 3'b110;
    haz_pass = 1'b1; alu_a = 8'h09; alu_b = 8'h04;
    for (int i = 0; i < 6; i++) begin
      opcode = seq[i];
      tick();
      n_checks++;
      if (alu_ctrl !== exp_alu_tbl[seq[i]]) begin
        n_errors++; $display("FAIL b2b_step%0d: got %b expected %b", i, alu_ctrl, exp_alu_tbl[seq[i]]);
      end
    end
    // Reset mid-stream overrides a passing SUB op.
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (alu_ctrl !== 2'b00 || alu_out !== 8'h0D) begin
      n_errors++; $display("FAIL b2b_reset: got %b/%h expected 00/0D", alu_ctrl, alu_out);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0; haz_pass = 1'b0; opcode = 3'b000;
    alu_a = 8'h00; alu_b = 8'h00;
    test_reset();
    test_decode_sweep();
    test_bubble();
    test_add_wrap();
    test_slt();
    test_sub_passb();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
